// File: rtl/mems_spi_pkg.sv
// Shared MEMS DAC SPI definitions: FSM state encoding and DAC frame width.
// Also used by the sequencer so both sides agree on the frame size.
package mems_spi_pkg;

  localparam int DAC_FRAME_W = 24;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP
  } spi_state_t;

endpackage

// File: rtl/mems_spi_tick.sv
// SCLK phase prescaler: one-cycle tick every HALF_DIV cycles, held in reset by clr.
// Latency: first tick HALF_DIV cycles after clr drops; no backpressure.
module mems_spi_tick #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(HALF_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  assign tick = !clr && (div_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr || (div_cnt == CNT_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mems_dac_spi_master.sv
// 3-wire SPI master for the MEMS quad DAC; busy for 2*HALF_DIV*DATA_W+GAP_CYC cycles per word.
// Backpressure: start is only sampled while busy is low; requests during busy are dropped.
module mems_dac_spi_master
  import mems_spi_pkg::*;
#(
  parameter int DATA_W   = DAC_FRAME_W,
  parameter int HALF_DIV = 2,
  parameter int GAP_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic              spi_sync_n,
  output logic              spi_mosi
);

  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam int GAP_W = $clog2(GAP_CYC) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  spi_state_t        state;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              tick;
  logic              tick_clr;

  // Prescaler held clear outside SHIFT so the first high phase is a full HALF_DIV.
  assign tick_clr = (state != SHIFT);

  mems_spi_tick #(
    .HALF_DIV(HALF_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      spi_sclk   <= 1'b1;
      spi_sync_n <= 1'b1;
      spi_mosi   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg      <= data_in;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            spi_sync_n <= 1'b0;
            spi_mosi   <= data_in[DATA_W-1];
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (spi_sclk) begin
              spi_sclk <= 1'b0;
            end else begin
              // End of a low phase: the DAC has sampled this bit on the fall.
              spi_sclk <= 1'b1;
              if (bit_cnt == BIT_LAST) begin
                spi_sync_n <= 1'b1;
                spi_mosi   <= 1'b0;
                gap_cnt    <= '0;
                state      <= GAP;
              end else begin
                shreg    <= {shreg[DATA_W-2:0], 1'b0};
                spi_mosi <= shreg[DATA_W-2];
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mems_dac_spi_master.sv
// Bench: default and fastest (HALF_DIV=1, GAP_CYC=1) masters share one randomized stimulus,
// each compared against a transaction-level model of accepts, latency and frame contents.
module tb_mems_dac_spi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] data_in;
  logic        busy    [2];
  logic        done    [2];
  logic        sclk    [2];
  logic        sync_n  [2];
  logic        mosi    [2];

  int n_checks = 0;
  int n_fail   = 0;
  event ckpt;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int H   = (g == 0) ? 2 : 1;
    localparam int G   = (g == 0) ? 2 : 1;
    localparam int LAT = 2 * H * 24 + G;

    mems_dac_spi_master #(
      .DATA_W  (24),
      .HALF_DIV(H),
      .GAP_CYC (G)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .data_in   (data_in),
      .busy      (busy[g]),
      .done      (done[g]),
      .spi_sclk  (sclk[g]),
      .spi_sync_n(sync_n[g]),
      .spi_mosi  (mosi[g])
    );

    // Transaction model: a request is taken whenever the previous word's busy window has
    // expired; each accepted word then occupies exactly LAT cycles.
    int          left;
    logic [23:0] exp_w   [64];
    bit          exp_b2b [64];
    logic [5:0]  wr;
    logic        mdl_done;
    int          mdl_frames = 0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        left     <= 0;
        wr       <= '0;
        mdl_done <= 1'b0;
      end else begin
        mdl_done <= (left == 1);
        if (left == 1) mdl_frames <= mdl_frames + 1;
        if (left == 0 && start) begin
          exp_w[wr]   <= data_in;
          exp_b2b[wr] <= mdl_done;
          wr          <= wr + 1'b1;
          left        <= LAT;
        end else if (left != 0) begin
          left <= left - 1;
        end
      end
    end

    // Wire-level observer: reconstructs words from the bits present at each SCLK fall.
    logic [5:0]  rd;
    logic [23:0] shw;
    int          nfall, brun, hi_run;
    int          frames_seen = 0;
    int          dones_seen  = 0;
    logic        p_sclk, p_sync;

    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd     <= '0;
        shw    <= '0;
        nfall  <= 0;
        brun   <= 0;
        hi_run <= 0;
        p_sclk <= 1'b1;
        p_sync <= 1'b1;
      end else begin
        check($sformatf("d%0d_busy", g), 32'(busy[g]), 32'(left != 0));
        check($sformatf("d%0d_done", g), 32'(done[g]), 32'(mdl_done));
        if (left == 0) begin
          check($sformatf("d%0d_idle_sclk", g), 32'(sclk[g]), 32'd1);
          check($sformatf("d%0d_idle_sync", g), 32'(sync_n[g]), 32'd1);
          check($sformatf("d%0d_idle_mosi", g), 32'(mosi[g]), 32'd0);
        end
        if (p_sclk && !sclk[g] && !sync_n[g]) begin
          shw   <= {shw[22:0], mosi[g]};
          nfall <= nfall + 1;
        end
        // Back-to-back: sync_n stays high for the GAP_CYC gap cycles plus the done cycle.
        if (p_sync && !sync_n[g] && exp_b2b[rd])
          check($sformatf("d%0d_gap", g), 32'(hi_run), 32'(G + 1));
        if (!p_sync && sync_n[g]) begin
          check($sformatf("d%0d_word", g), 32'(shw), 32'(exp_w[rd]));
          check($sformatf("d%0d_falls", g), 32'(nfall), 32'd24);
          rd          <= rd + 1'b1;
          nfall       <= 0;
          frames_seen <= frames_seen + 1;
        end
        hi_run <= sync_n[g] ? hi_run + 1 : 0;
        if (busy[g]) begin
          brun <= brun + 1;
        end else if (brun != 0) begin
          check($sformatf("d%0d_busy_len", g), 32'(brun), 32'(LAT));
          brun <= 0;
        end
        if (done[g]) dones_seen <= dones_seen + 1;
        p_sclk <= sclk[g];
        p_sync <= sync_n[g];
      end
    end

    always @(ckpt) begin
      check($sformatf("d%0d_frame_cnt", g), 32'(frames_seen), 32'(mdl_frames));
      check($sformatf("d%0d_done_cnt", g), 32'(dones_seen), 32'(mdl_frames));
      check($sformatf("d%0d_drained", g), 32'(rd), 32'(wr));
    end
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    cyc(3);
    rst_n = 1'b1;

    // Idle after reset.
    cyc(20);
    -> ckpt;

    // Single directed frame.
    start = 1'b1; data_in = 24'h3FA5C3;
    cyc(1);
    start = 1'b0; data_in = 24'($urandom);
    cyc(120);
    -> ckpt;

    // Requests arriving mid-frame.
    start = 1'b1; data_in = 24'($urandom);
    cyc(1);
    start = 1'b0;
    cyc(4);
    start = 1'b1; data_in = 24'($urandom);
    cyc(1);
    start = 1'b0;
    cyc(44);
    start = 1'b1; data_in = 24'($urandom);
    cyc(1);
    start = 1'b0;
    cyc(120);
    -> ckpt;

    // Start held high with alternating data.
    for (int i = 0; i < 300; i++) begin
      start   = 1'b1;
      data_in = (i % 2 == 0) ? 24'hAAAAAA : 24'h555555;
      cyc(1);
    end
    start = 1'b0;
    cyc(120);
    -> ckpt;

    // Random request traffic.
    for (int i = 0; i < 600; i++) begin
      start   = ($urandom_range(0, 7) == 0);
      data_in = 24'($urandom);
      cyc(1);
    end
    start = 1'b0;
    cyc(120);
    -> ckpt;

    // Reset in the middle of a frame (bit 10 of the default instance).
    start = 1'b1; data_in = 24'($urandom);
    cyc(1);
    start = 1'b0;
    cyc(40);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d_arst_busy", k), 32'(busy[k]), 32'd0);
      check($sformatf("d%0d_arst_done", k), 32'(done[k]), 32'd0);
      check($sformatf("d%0d_arst_sclk", k), 32'(sclk[k]), 32'd1);
      check($sformatf("d%0d_arst_sync", k), 32'(sync_n[k]), 32'd1);
      check($sformatf("d%0d_arst_mosi", k), 32'(mosi[k]), 32'd0);
    end
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    start = 1'b1; data_in = 24'h000001;
    cyc(1);
    start = 1'b0;
    cyc(120);
    -> ckpt;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
